twiddle_mult_arbiter: RTL and testbench

Shares one W8 twiddle complex-multiplier datapath (`complex_multiplier_FFT`) between two requesters, e.g. two FFT butterfly lanes. Each lane gets a valid/ready request channel and a valid/ready response channel. The block grants the datapath round-robin, drives its operand and control inputs, and tracks every in-flight operation through the fixed-latency pipeline with a tag. Each result is returned to the lane that issued it, and the datapath is stalled with `mul_en` when a result cannot be delivered.

---
 rtl/fft_pkg.sv | 16 +
 rtl/rr_arb2.sv | 42 ++++
 rtl/twiddle_mult_arbiter.sv | 99 +++++++++
 tb/tb_twiddle_mult_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT constants and types: datapath width, W8 twiddle multiplier
// latency, and the lane-id tag carried alongside in-flight operations.
package fft_pkg;

  localparam int DW         = 16;
  localparam int W8_LATENCY = 2;
  localparam int ID_W       = 1;

  typedef logic [ID_W-1:0] lane_id_t;

  typedef struct packed {
    logic     valid;
    lane_id_t id;
  } tag_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. On a tie the lane other than the most
// recently granted one wins; last_grant only moves when a grant is used.
module rr_arb2
  import fft_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last_grant_q;
  logic last_grant_d;

  // NOTE: every output of a combinational block gets a default on entry;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    gnt          = 2'b00;
    last_grant_d = last_grant_q;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_grant_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
    if (advance && (gnt != 2'b00)) begin
      last_grant_d = gnt[1];
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // its pre-edge value; reset is synchronous and checked first.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/twiddle_mult_arbiter.sv
// Shares one fixed-latency W8 twiddle complex multiplier between two lanes,
// tagging each operation so its result returns to the issuing lane in order.
module twiddle_mult_arbiter
  import fft_pkg::*;
#(
  parameter int DW      = fft_pkg::DW,
  parameter int LATENCY = fft_pkg::W8_LATENCY
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req_valid,
  output logic [1:0]    req_ready,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  input  logic [1:0]    req_ctrl,
  output logic [1:0]    rsp_valid,
  input  logic [1:0]    rsp_ready,
  output logic [DW-1:0] rsp_r,
  output logic [DW-1:0] rsp_i,
  output logic [DW-1:0] mul_a,
  output logic [DW-1:0] mul_b,
  output logic          mul_ctrl,
  output logic          mul_en,
  input  logic [DW-1:0] mul_r,
  input  logic [DW-1:0] mul_i
);

  tag_t       tag_q [LATENCY];
  tag_t       tag_d [LATENCY];
  tag_t       head;
  logic       stall;
  logic       issue;
  logic       sel;
  logic [1:0] gnt_raw;
  logic [1:0] gnt;

  assign head   = tag_q[LATENCY-1];
  assign stall  = head.valid & ~rsp_ready[head.id];
  assign mul_en = ~stall & ~rst;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (mul_en),
    .gnt     (gnt_raw)
  );

  // A frozen datapath cannot take operands, so grants only count while it moves.
  assign gnt       = gnt_raw & {2{mul_en}};
  assign issue     = |gnt;
  assign sel       = gnt[1];
  assign req_ready = gnt;

  always_comb begin
    mul_a    = '0;
    mul_b    = '0;
    mul_ctrl = 1'b0;
    if (issue) begin
      mul_a    = sel ? req1_a : req0_a;
      mul_b    = sel ? req1_b : req0_b;
      mul_ctrl = req_ctrl[sel];
    end
  end

  // Tags move in lockstep with the datapath; a consumed head leaves on the
  // same edge that a new operation enters stage 0.
  always_comb begin
    for (int s = 0; s < LATENCY; s++) begin
      tag_d[s] = tag_q[s];
    end
    if (mul_en) begin
      tag_d[0] = '{valid: issue, id: lane_id_t'(sel)};
      for (int s = 1; s < LATENCY; s++) begin
        tag_d[s] = tag_q[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < LATENCY; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < LATENCY; s++) begin
        tag_q[s] <= tag_d[s];
      end
    end
  end

  assign rsp_valid[0] = head.valid & (head.id == lane_id_t'(0)) & ~rst;
  assign rsp_valid[1] = head.valid & (head.id == lane_id_t'(1)) & ~rst;
  assign rsp_r        = mul_r;
  assign rsp_i        = mul_i;

endmodule

// File: tb/tb_twiddle_mult_arbiter.sv
// Bench for twiddle_mult_arbiter: a stub W8 datapath, a queue-based model of
// the arbitration and in-order return, directed scenarios plus a random phase.
module tb_twiddle_mult_arbiter;
  import fft_pkg::*;

  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]    req_ctrl;
  logic [1:0]    rsp_valid;
  logic [1:0]    rsp_ready;
  logic [DW-1:0] rsp_r, rsp_i;
  logic [DW-1:0] mul_a, mul_b;
  logic          mul_ctrl;
  logic          mul_en;
  logic [DW-1:0] mul_r, mul_i;

  always #5 clk = ~clk;

  twiddle_mult_arbiter #(.DW(DW), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req_ctrl(req_ctrl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_r(rsp_r), .rsp_i(rsp_i),
    .mul_a(mul_a), .mul_b(mul_b), .mul_ctrl(mul_ctrl), .mul_en(mul_en),
    .mul_r(mul_r), .mul_i(mul_i)
  );

  // W8 twiddle: ctrl=0 multiplies by 1, ctrl=1 by (1-j)/sqrt2 in Q8 (181/256).
  function automatic logic [31:0] dp_fn(input logic [15:0] a, input logic [15:0] b,
                                        input logic c);
    int sa, sb, r, i;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!c) begin
      r = sa;
      i = sb;
    end else begin
      r = ((sa + sb) * 181) >>> 8;
      i = ((sb - sa) * 181) >>> 8;
    end
    return {r[15:0], i[15:0]};
  endfunction

  // Cycle-accurate datapath stub: two stages, both advanced by mul_en.
  logic [31:0] dp_s1, dp_s2;
  always_ff @(posedge clk) begin
    if (mul_en) begin
      dp_s1 <= dp_fn(mul_a, mul_b, mul_ctrl);
      dp_s2 <= dp_s1;
    end
  end
  assign mul_r = dp_s2[31:16];
  assign mul_i = dp_s2[15:0];

  typedef struct {
    int          lane;
    logic [31:0] res;
    int          wt;
  } exp_t;

  exp_t       q[$];
  int         last_lane;
  logic [1:0] acc;
  int         vectors     = 0;
  int         miscompares = 0;
  int         rem[2];
  bit         rnd_mode;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lane_a(input int k);
    return (k == 0) ? req0_a : req1_a;
  endfunction

  function automatic logic [15:0] lane_b(input int k);
    return (k == 0) ? req0_b : req1_b;
  endfunction

  // Reference: in-order queue of expected results, each waiting LAT-1 moving
  // edges after issue before it shows at the head.
  task automatic model_step();
    bit         head_ok, stl;
    int         g;
    logic [1:0] exp_rv, exp_rr;
    logic [31:0] exp_a, exp_b, exp_c;
    if (rst) begin
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_mul_en", 32'(mul_en), 32'd0);
      check("rst_mul_ops", {mul_a, mul_b} | 32'(mul_ctrl), 32'd0);
      q.delete();
      last_lane = 1;
      acc = 2'b00;
      return;
    end
    head_ok = (q.size() > 0) && (q[0].wt == 0);
    stl     = head_ok && !rsp_ready[q[0].lane];
    exp_rv  = head_ok ? (2'b01 << q[0].lane) : 2'b00;
    g = -1;
    if (req_valid == 2'b11) g = 1 - last_lane;
    else if (req_valid == 2'b01) g = 0;
    else if (req_valid == 2'b10) g = 1;
    exp_rr = (!stl && g >= 0) ? (2'b01 << g) : 2'b00;
    exp_a = 0; exp_b = 0; exp_c = 0;
    if (exp_rr != 0) begin
      exp_a = 32'(lane_a(g));
      exp_b = 32'(lane_b(g));
      exp_c = 32'(req_ctrl[g]);
    end
    check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    check("req_ready", 32'(req_ready), 32'(exp_rr));
    check("mul_en", 32'(mul_en), 32'(!stl));
    check("mul_a", 32'(mul_a), exp_a);
    check("mul_b", 32'(mul_b), exp_b);
    check("mul_ctrl", 32'(mul_ctrl), exp_c);
    if (head_ok) check("rsp_ri", {rsp_r, rsp_i}, q[0].res);
    acc = exp_rr;
    if (!stl) begin
      if (head_ok) void'(q.pop_front());
      foreach (q[n]) if (q[n].wt > 0) q[n].wt--;
      if (g >= 0) begin
        q.push_back('{lane: g, res: dp_fn(lane_a(g), lane_b(g), req_ctrl[g]), wt: LAT - 1});
        last_lane = g;
      end
    end
  endtask

  task automatic set_op(input int k, input logic [15:0] a, input logic [15:0] b,
                        input logic c);
    if (k == 0) begin
      req0_a = a; req0_b = b;
    end else begin
      req1_a = a; req1_b = b;
    end
    req_ctrl[k] = c;
  endtask

  task automatic start_stream(input int k, input int n, input logic [15:0] a,
                              input logic [15:0] b, input logic c);
    rem[k] = n;
    set_op(k, a, b, c);
    req_valid[k] = 1'b1;
  endtask

  // Each cycle: check at the falling edge, then after the rising edge retire
  // accepted requests, holding the rest stable as requesters must.
  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (acc[k]) begin
          rem[k]--;
          if (rem[k] > 0) set_op(k, lane_a(k) + 16'd1, lane_b(k), req_ctrl[k]);
          else req_valid[k] = 1'b0;
        end
        if (rnd_mode && !req_valid[k] && ($urandom_range(1, 0) == 1)) begin
          start_stream(k, 1, 16'($urandom), 16'($urandom), 1'($urandom));
        end
      end
      if (rnd_mode) rsp_ready = 2'($urandom_range(3, 0) | $urandom_range(3, 0));
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 2'b11; rsp_ready = 2'b11; req_ctrl = 2'b00;
    req0_a = 16'h1111; req0_b = 16'h2222; req1_a = 16'h3333; req1_b = 16'h4444;
    rem = '{0, 0}; rnd_mode = 1'b0; last_lane = 1; acc = 2'b00;

    // Reset with both lanes requesting.
    run(3);
    rst = 1'b0; req_valid = 2'b00;
    run(7);

    // Single lane 0 operation, then a lone lane 1 twiddled operation.
    start_stream(0, 1, 16'h0100, 16'h0000, 1'b0);
    run(4);
    start_stream(1, 1, 16'h0040, 16'hFFC0, 1'b1);
    run(4);

    // Contention: six operations per lane.
    start_stream(0, 6, 16'h0010, 16'h0001, 1'b0);
    start_stream(1, 6, 16'h0020, 16'h0002, 1'b1);
    run(16);

    // Backpressure on lane 1 while lane 0 keeps requesting.
    rsp_ready = 2'b01;
    start_stream(1, 1, 16'h0123, 16'h0456, 1'b1);
    run(1);
    start_stream(0, 3, 16'h0700, 16'h0800, 1'b0);
    run(5);
    rsp_ready = 2'b11;
    run(8);

    // Bubbles: issues at relative cycles 0, 3 and 4.
    start_stream(0, 1, 16'h0A00, 16'h0B00, 1'b1);
    run(3);
    start_stream(0, 2, 16'h0C00, 16'h0D00, 1'b0);
    run(6);

    // Reset while two results are in flight, then a tie.
    start_stream(0, 1, 16'h0E00, 16'h0F00, 1'b0);
    run(1);
    start_stream(1, 1, 16'h1E00, 16'h1F00, 1'b1);
    run(1);
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    start_stream(0, 1, 16'h2000, 16'h2100, 1'b0);
    start_stream(1, 1, 16'h3000, 16'h3100, 1'b1);
    run(6);

    // Random traffic with random response backpressure, then drain.
    rnd_mode = 1'b1;
    run(400);
    rnd_mode = 1'b0;
    rsp_ready = 2'b11;
    run(12);
    check("drained", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
